pulse_train_gen: RTL and testbench

- Upstream stimulus stage for the tap-delay block. Produces 1-cycle `data` and `data2` strobes on a programmable period. The delay line consumes these strobes and derives its delayed taps and combined wave from them.
- A per-slot mask pattern lets individual pulses be dropped, so the delay stage sees both regular gaps and missing-pulse gaps.
- `cnt` exposes the in-period phase for alignment with the downstream counter.

---
 rtl/pulse_train_gen.sv | 176 +++++++++++++++++
 tb/tb_pulse_train_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// pulse_train_gen
// Stimulus source for the tap-delay block. Emits a 1-cycle masked strobe
// (data) and an unmasked reference strobe (data2) once per programmable
// period. The slot mask walks through PAT_W slots, slot 0 first.
//
// Build option:
//   PTG_ONESHOT_EN - when defined, each start emits exactly one frame of
//                    PAT_W slots and the block then returns to IDLE.
//                    When undefined, frames repeat until stop or rst.
module pulse_train_gen #(
    parameter int                CNT_W       = 5,
    parameter int                PAT_W       = 8,
    parameter int                DEF_PERIOD  = 19,
    parameter logic [PAT_W-1:0]  DEF_PATTERN = 8'h5B
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_ld,
    input  logic [CNT_W-1:0]          period_in,
    input  logic [PAT_W-1:0]          pattern_in,
    input  logic                      start,
    input  logic                      stop,
    output logic                      data,
    output logic                      data2,
    output logic [CNT_W-1:0]          cnt,
    output logic [$clog2(PAT_W)-1:0]  slot,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int SLOT_W = $clog2(PAT_W);

`ifdef PTG_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   period_r;
    logic [PAT_W-1:0]   pattern_r;

    logic [CNT_W-1:0]   cnt_nxt;
    logic [SLOT_W-1:0]  slot_nxt;
    logic               data_nxt;
    logic               data2_nxt;
    logic               busy_nxt;
    logic               frame_done_nxt;

    // Helpers describing where the current cycle sits in the period/frame.
    logic               last_cyc;
    logic               slot_last;
    logic [SLOT_W-1:0]  slot_inc;

    assign last_cyc  = (cnt == period_r - CNT_W'(1));
    assign slot_last = (slot == SLOT_W'(PAT_W - 1));
    assign slot_inc  = slot_last ? '0 : slot + SLOT_W'(1);

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Period/pattern configuration; only writable while the train is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_r  <= CNT_W'(DEF_PERIOD);
            pattern_r <= DEF_PATTERN;
        end else if (state == IDLE && cfg_ld) begin
            period_r  <= (period_in < CNT_W'(2)) ? CNT_W'(2) : period_in;
            pattern_r <= pattern_in;
        end
    end

    // Next-state logic: stop beats start in IDLE, STOP drains the period.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (ONESHOT && last_cyc && slot_last) begin
                    state_nxt = IDLE;
                end else if (stop) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (last_cyc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; strobes only on edges that
    // enter or stay in RUN at a period boundary.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        cnt_nxt        = '0;
        slot_nxt       = '0;
        data_nxt       = 1'b0;
        data2_nxt      = 1'b0;
        busy_nxt       = 1'b0;
        frame_done_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (state_nxt == RUN) begin
                    data_nxt  = pattern_r[0];
                    data2_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            RUN, STOP: begin
                if (state_nxt != IDLE) begin
                    busy_nxt = 1'b1;
                    if (last_cyc) begin
                        slot_nxt = slot_inc;
                        if (state == RUN && state_nxt == RUN) begin
                            data_nxt  = pattern_r[slot_inc];
                            data2_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt  = cnt + CNT_W'(1);
                        slot_nxt = slot;
                    end
                end
            end
            default: ;
        endcase

        frame_done_nxt = (state_nxt != IDLE)
                       && (cnt_nxt == period_r - CNT_W'(1))
                       && (slot_nxt == SLOT_W'(PAT_W - 1));
    end

    // Output register; every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            slot       <= '0;
            data       <= 1'b0;
            data2      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            slot       <= slot_nxt;
            data       <= data_nxt;
            data2      <= data2_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen
// Self-checking bench for pulse_train_gen. A reference model tracks each
// pulse train as a start time plus an optional stop point and derives the
// expected phase, slot and strobes arithmetically from the elapsed cycles.
module tb_pulse_train_gen;

    localparam int          CNT_W       = 5;
    localparam int          PAT_W       = 8;
    localparam int          DEF_PERIOD  = 19;
    localparam logic [7:0]  DEF_PATTERN = 8'h5B;
    localparam int          NO_STOP     = 1 << 30;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_ld = 1'b0;
    logic [CNT_W-1:0]  period_in = '0;
    logic [PAT_W-1:0]  pattern_in = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              data;
    logic              data2;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        slot;
    logic              busy;
    logic              frame_done;

    always #5 clk = ~clk;

    pulse_train_gen #(
        .CNT_W       (CNT_W),
        .PAT_W       (PAT_W),
        .DEF_PERIOD  (DEF_PERIOD),
        .DEF_PATTERN (DEF_PATTERN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_ld     (cfg_ld),
        .period_in  (period_in),
        .pattern_in (pattern_in),
        .start      (start),
        .stop       (stop),
        .data       (data),
        .data2      (data2),
        .cnt        (cnt),
        .slot       (slot),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "reset";
    logic  prev_data = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d (t=%0t)", phase, tag, got, exp, $time);
        end
    endtask

    // Reference model: configuration registers plus the active train.
    int          m_period  = DEF_PERIOD;
    logic [7:0]  m_pattern = DEF_PATTERN;
    bit          tr_active = 1'b0;
    int          tr_rel    = 0;       // cycles since the train's first strobe
    int          tr_p      = DEF_PERIOD;
    logic [7:0]  tr_pat    = DEF_PATTERN;
    int          tr_stop   = NO_STOP; // relative cycle where stop was taken

    function automatic int end_rel();
        int e;
        e = NO_STOP;
        if (tr_stop != NO_STOP) e = ((tr_stop + 1) / tr_p + 1) * tr_p - 1;
`ifdef PTG_ONESHOT_EN
        if (e > PAT_W * tr_p - 1) e = PAT_W * tr_p - 1;
`endif
        return e;
    endfunction

    task automatic model_reset();
        m_period  = DEF_PERIOD;
        m_pattern = DEF_PATTERN;
        tr_active = 1'b0;
        tr_rel    = 0;
        tr_stop   = NO_STOP;
    endtask

    task automatic model_edge(input logic st, input logic sp, input logic ld,
                              input logic [4:0] pin, input logic [7:0] patin);
        if (!tr_active) begin
            if (ld) begin
                m_period  = (int'(pin) < 2) ? 2 : int'(pin);
                m_pattern = patin;
            end
            if (st && !sp) begin
                tr_active = 1'b1;
                tr_rel    = 0;
                tr_p      = m_period;
                tr_pat    = m_pattern;
                tr_stop   = NO_STOP;
            end
        end else begin
            if (sp && tr_stop == NO_STOP) tr_stop = tr_rel;
            tr_rel++;
            if (tr_rel > end_rel()) tr_active = 1'b0;
        end
    endtask

    function automatic int m_cnt();
        return tr_active ? tr_rel % tr_p : 0;
    endfunction

    function automatic int m_slot();
        return tr_active ? (tr_rel / tr_p) % PAT_W : 0;
    endfunction

    task automatic compare();
        logic e_data2, e_data, e_fd;
        int   e_cnt, e_slot;
        e_cnt   = m_cnt();
        e_slot  = m_slot();
        e_data2 = tr_active && (e_cnt == 0) && (tr_rel <= tr_stop);
        e_data  = e_data2 && tr_pat[e_slot];
        e_fd    = tr_active && (e_cnt == tr_p - 1) && (e_slot == PAT_W - 1);
        check("data",       32'(data),       32'(e_data));
        check("data2",      32'(data2),      32'(e_data2));
        check("cnt",        32'(cnt),        32'(e_cnt));
        check("slot",       32'(slot),       32'(e_slot));
        check("busy",       32'(busy),       32'(tr_active));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("data_width", 32'(data & prev_data), 32'd0);
    endtask

    // One clock: check the current cycle, drive inputs, advance model.
    task automatic step(input logic st, input logic sp, input logic ld,
                        input logic [4:0] pin, input logic [7:0] patin);
        compare();
        prev_data  = data;
        start      = st;
        stop       = sp;
        cfg_ld     = ld;
        period_in  = pin;
        pattern_in = patin;
        @(posedge clk);
        model_edge(st, sp, ld, pin, patin);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    endtask

    // Advance until the model reaches the requested phase (slot<0: any slot).
    task automatic run_until(input int c, input int s, input int budget);
        int k;
        k = 0;
        while (!(tr_active && m_cnt() == c && (s < 0 || m_slot() == s)) && k < budget) begin
            idle_cycles(1);
            k++;
        end
        check("wait_bound", 32'(k < budget), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(data),       32'd0);
        check({tag, "_data2"}, 32'(data2),      32'd0);
        check({tag, "_cnt"},   32'(cnt),        32'd0);
        check({tag, "_slot"},  32'(slot),       32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_fd"},    32'(frame_done), 32'd0);
    endtask

    initial begin
        int dcnt, fdcnt;
        logic st, sp, ld;

        // Reset state.
        #1 rst = 1'b1;
        #2;
        check_all_zero("rst");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Default period/mask, single start pulse.
        phase = "defaults";
        idle_cycles(2);
        step(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        dcnt  = 0;
        fdcnt = 0;
        repeat (PAT_W * DEF_PERIOD) begin
            dcnt  += int'(data);
            fdcnt += int'(frame_done);
            idle_cycles(1);
        end
        check("frame_strobes", 32'(dcnt),  32'($countones(DEF_PATTERN)));
        check("frame_dones",   32'(fdcnt), 32'd1);
        idle_cycles(180);
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
        idle_cycles(40);

        // Short period, all slots enabled.
        phase = "p5_ff";
        step(1'b0, 1'b0, 1'b1, 5'd5, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        idle_cycles(30);
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
        idle_cycles(10);

        // Period clamp for 1 and 0.
        phase = "clamp1";
        step(1'b0, 1'b0, 1'b1, 5'd1, 8'hA5);
        step(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        idle_cycles(20);
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
        idle_cycles(5);
        phase = "clamp0";
        step(1'b0, 1'b0, 1'b1, 5'd0, 8'h3C);
        step(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        idle_cycles(20);
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
        idle_cycles(5);

        // start and stop together in IDLE: stop wins.
        phase = "start_stop";
        step(1'b1, 1'b1, 1'b0, 5'd0, 8'd0);
        idle_cycles(5);

        // Graceful stop at cnt=7 with the default period.
        phase = "stop_cnt7";
        step(1'b0, 1'b0, 1'b1, 5'd19, DEF_PATTERN);
        step(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        run_until(7, 1, 100);
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
        idle_cycles(25);

        // cfg_ld during RUN is ignored.
        phase = "cfg_in_run";
        step(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        idle_cycles(3);
        step(1'b0, 1'b0, 1'b1, 5'd3, 8'h0F);
        idle_cycles(60);
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
        idle_cycles(25);

        // Asynchronous reset at cnt=10, slot=3, then restart.
        phase = "async_rst";
        step(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        run_until(10, 3, 200);
        compare();
        #2 rst = 1'b1;
        #1;
        check_all_zero("async");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        prev_data = 1'b0;
        step(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        idle_cycles(25);
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
        idle_cycles(25);

        // Randomized traffic against the model.
        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 39) == 0);
            ld = !st && ($urandom_range(0, 9) == 0);
            step(st, sp, ld, 5'($urandom_range(0, 31)), 8'($urandom));
        end
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
